// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a 3-digit common-anode 7-segment display.
// Each digit slot opens with an all-off guard, and a frame snapshot keeps the digits consistent.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [20:0] seven_segs,
    input  logic        enable,
    input  logic        blank_leading,
    output logic [6:0]  seg_out,
    output logic [2:0]  dig_en_n,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [6:0]    SEG_OFF    = 7'h7F;
    localparam logic [6:0]    SEG_ZERO   = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t         state_r;
    logic [1:0]     idx_r;
    logic [CW-1:0]  cnt_r;
    logic [20:0]    snapshot_r;
    logic [6:0]     drive_seg_s;
    logic [2:0]     drive_dig_s;

    function automatic logic [6:0] digit_of(input logic [20:0] snap, input logic [1:0] idx);
        logic [6:0] pat;
        case (idx)
            2'd0:    pat = snap[6:0];
            2'd1:    pat = snap[13:7];
            2'd2:    pat = snap[20:14];
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    // Leading zeros blank only while every more-significant digit is also blank.
    function automatic logic is_suppressed(input logic [20:0] snap, input logic [1:0] idx,
                                           input logic bl);
        logic hund_zero;
        logic tens_zero;
        logic sup;
        hund_zero = (snap[20:14] == SEG_ZERO);
        tens_zero = (snap[13:7] == SEG_ZERO);
        case (idx)
            2'd2:    sup = bl && hund_zero;
            2'd1:    sup = bl && hund_zero && tens_zero;
            default: sup = 1'b0;
        endcase
        return sup;
    endfunction

    // Pattern and digit enable to load when the current slot enters DRIVE.
    always_comb begin
        drive_seg_s = SEG_OFF;
        drive_dig_s = 3'b111;
        if (is_suppressed(snapshot_r, idx_r, blank_leading)) begin
            drive_seg_s = SEG_OFF;
            drive_dig_s = 3'b111;
        end else begin
            drive_seg_s = digit_of(snapshot_r, idx_r);
            case (idx_r)
                2'd0:    drive_dig_s = 3'b110;
                2'd1:    drive_dig_s = 3'b101;
                2'd2:    drive_dig_s = 3'b011;
                default: drive_dig_s = 3'b111;
            endcase
        end
    end

    // Scan FSM with registered outputs; enable low overrides everything, including a frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= 2'd0;
            cnt_r      <= '0;
            snapshot_r <= 21'h1FFFFF;
            seg_out    <= SEG_OFF;
            dig_en_n   <= 3'b111;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!enable) begin
                state_r  <= IDLE;
                idx_r    <= 2'd0;
                cnt_r    <= '0;
                seg_out  <= SEG_OFF;
                dig_en_n <= 3'b111;
            end else begin
                case (state_r)
                    IDLE: begin
                        snapshot_r <= seven_segs;
                        idx_r      <= 2'd0;
                        cnt_r      <= '0;
                        state_r    <= BLANK;
                        seg_out    <= SEG_OFF;
                        dig_en_n   <= 3'b111;
                    end
                    BLANK: begin
                        if (cnt_r == BLANK_LAST) begin
                            cnt_r    <= '0;
                            state_r  <= DRIVE;
                            seg_out  <= drive_seg_s;
                            dig_en_n <= drive_dig_s;
                        end else begin
                            cnt_r    <= cnt_r + CNT_ONE;
                            seg_out  <= SEG_OFF;
                            dig_en_n <= 3'b111;
                        end
                    end
                    DRIVE: begin
                        if (cnt_r == DRIVE_LAST) begin
                            cnt_r    <= '0;
                            state_r  <= BLANK;
                            seg_out  <= SEG_OFF;
                            dig_en_n <= 3'b111;
                            if (idx_r == 2'd2) begin
                                idx_r      <= 2'd0;
                                snapshot_r <= seven_segs;
                                frame_done <= 1'b1;
                            end else begin
                                idx_r <= idx_r + 2'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        idx_r    <= 2'd0;
                        cnt_r    <= '0;
                        seg_out  <= SEG_OFF;
                        dig_en_n <= 3'b111;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues hand-computed per-cycle outputs,
// and a negedge monitor pops and compares them.
module tb_seg_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D2  = 7'b0100100;
    localparam logic [6:0] D3  = 7'b0110000;
    localparam logic [6:0] D4  = 7'b0011001;
    localparam logic [6:0] D5  = 7'b0010010;
    localparam logic [6:0] D6  = 7'b0000010;
    localparam logic [6:0] D7  = 7'b1111000;
    localparam logic [6:0] OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        blank_leading = 1'b0;
    logic [20:0] seven_segs = 21'h0;
    logic [6:0]  seg_out;
    logic [2:0]  dig_en_n;
    logic        frame_done;

    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    int          mon_n = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seven_segs    (seven_segs),
        .enable        (enable),
        .blank_leading (blank_leading),
        .seg_out       (seg_out),
        .dig_en_n      (dig_en_n),
        .frame_done    (frame_done)
    );

    // Monitor: compares one queued expectation per cycle, on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({seg_out, dig_en_n, frame_done} !== mon_e) begin
                failures++;
                $display("FAIL out_cyc%0d got seg=%b dig=%b fd=%b exp seg=%b dig=%b fd=%b",
                         mon_n, seg_out, dig_en_n, frame_done, mon_e[10:4], mon_e[3:1], mon_e[0]);
            end
            mon_n++;
        end
    end

    task automatic cyc(input logic [6:0] s, input logic [2:0] d, input logic f);
        @(posedge clk);
        #1;
        exp_q.push_back({s, d, f});
    endtask

    // Expected slot contents u/t/h (OFF = suppressed slot); optional input change after cycle chg_at.
    task automatic frame(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h,
                         input logic fd0, input int ncyc, input int chg_at,
                         input logic [20:0] chg_val);
        int slot;
        int ph;
        logic [6:0] p;
        logic [2:0] d;
        for (int c = 0; c < ncyc; c++) begin
            slot = c / RD;
            ph   = c % RD;
            p    = (slot == 0) ? u : ((slot == 1) ? t : h);
            d    = (slot == 0) ? 3'b110 : ((slot == 1) ? 3'b101 : 3'b011);
            if (ph < BC || p == OFF) begin
                p = OFF;
                d = 3'b111;
            end
            cyc(p, d, (c == 0) ? fd0 : 1'b0);
            if (c == chg_at) seven_segs = chg_val;
        end
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        enable = 1'b1;
        seven_segs = {D1, D2, D3};
        repeat (5) cyc(OFF, 3'b111, 1'b0);
        rst_n = 1'b1;
        enable = 1'b0;
        repeat (20) cyc(OFF, 3'b111, 1'b0);

        // basic scan, then a mid-frame input change that must wait for the wrap
        enable = 1'b1;
        frame(D3, D2, D1, 1'b0, 3 * RD, -1, 21'h0);
        frame(D3, D2, D1, 1'b1, 3 * RD, 10, {D4, D5, D6});
        frame(D6, D5, D4, 1'b1, 3 * RD, -1, 21'h0);

        // enable drop mid-hundreds DRIVE, then restart from units with a fresh snapshot
        frame(D6, D5, D4, 1'b1, 20, -1, 21'h0);
        enable = 1'b0;
        repeat (5) cyc(OFF, 3'b111, 1'b0);
        seven_segs = {D1, D2, D3};
        enable = 1'b1;
        frame(D3, D2, D1, 1'b0, 3 * RD, -1, 21'h0);
        enable = 1'b0;  // falls on the frame-wrap edge: no frame_done
        repeat (3) cyc(OFF, 3'b111, 1'b0);

        // leading-zero suppression
        blank_leading = 1'b1;
        seven_segs = {D0, D0, D7};
        enable = 1'b1;
        frame(D7, OFF, OFF, 1'b0, 3 * RD, -1, 21'h0);
        seven_segs = {D0, D7, D0};
        frame(D0, D7, OFF, 1'b1, 3 * RD, -1, 21'h0);
        seven_segs = {D0, D0, D0};
        frame(D0, OFF, OFF, 1'b1, 3 * RD, -1, 21'h0);
        seven_segs = {D1, D0, D7};
        frame(D7, D0, D1, 1'b1, 3 * RD, -1, 21'h0);
        blank_leading = 1'b0;
        seven_segs = {D0, D0, D7};
        frame(D7, D0, D0, 1'b1, 3 * RD, -1, 21'h0);
        enable = 1'b0;
        repeat (3) cyc(OFF, 3'b111, 1'b0);

        // asynchronous reset between edges during the tens DRIVE slot
        seven_segs = {D1, D2, D3};
        enable = 1'b1;
        frame(D3, D2, D1, 1'b0, 12, -1, 21'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.push_back({OFF, 3'b111, 1'b0});
        #1;
        checks++;
        if ({seg_out, dig_en_n, frame_done} !== {OFF, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL async_rst got seg=%b dig=%b fd=%b exp seg=%b dig=111 fd=0",
                     seg_out, dig_en_n, frame_done, OFF);
        end
        repeat (2) cyc(OFF, 3'b111, 1'b0);
        rst_n = 1'b1;
        seven_segs = {D4, D5, D6};
        frame(D6, D5, D4, 1'b0, 3 * RD, -1, 21'h0);
        enable = 1'b0;
        repeat (2) cyc(OFF, 3'b111, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
